// File: rtl/adder_pkg.sv
// Shared definitions for the adder datapath and its ALU consumer.
package adder_pkg;

    localparam int unsigned ADDER_W_DEFAULT = 1;
    localparam int unsigned ADDER_W_MAX     = 64;

    // Reset value for every adder output register.
    localparam logic [ADDER_W_MAX-1:0] ADDER_RST_VAL = '0;

    // Result payload; the ALU uses the low w bits of sum.
    typedef struct packed {
        logic                   cout;
        logic [ADDER_W_MAX-1:0] sum;
    } adder_result_t;

    // Pack a carry/sum pair into the shared result type.
    function automatic adder_result_t adder_pack(input logic cout, input logic [ADDER_W_MAX-1:0] sum);
        adder_result_t r;
        r.cout = cout;
        r.sum  = sum;
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/adder_n_bit.sv
// w-bit unsigned ripple-carry adder with one registered output stage.
// Optional signed-overflow output enabled by defining ADDER_N_BIT_OVF_EN.
module adder_n_bit
    import adder_pkg::*;
#(
    parameter int unsigned w = ADDER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    input  logic         cin,
    input  logic         in_valid,
    output logic [w-1:0] sum,
    output logic         cout,
    output logic         out_valid
`ifdef ADDER_N_BIT_OVF_EN
    ,
    output logic         ovf
`endif
);

    logic [w:0]   carry;
    logic [w-1:0] sum_c;

    assign carry[0] = cin;

    // Ripple chain: stage i consumes the carry out of stage i-1.
    for (genvar i = 0; i < int'(w); i++) begin : g_stage
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum_c[i]),
            .cout (carry[i+1])
        );
    end

    // Output register: updates every edge, in_valid only rides along as out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= w'(ADDER_RST_VAL);
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            sum       <= sum_c;
            cout      <= carry[w];
            out_valid <= in_valid;
        end
    end

`ifdef ADDER_N_BIT_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= carry[w] ^ carry[w-1];
        end
    end
`endif

endmodule

// File: tb/tb_adder_n_bit.sv
// Bench for adder_n_bit at widths 1, 4, 8 and 32 against an arithmetic model.
module tb_adder_n_bit;

    logic clk;
    logic rst_n;

    logic [3:0]  a4, b4, s4;
    logic        c4, iv4, co4, ov4v;
    logic [0:0]  a1, b1, s1;
    logic        c1, iv1, co1, ov1v;
    logic [7:0]  a8, b8, s8;
    logic        c8, iv8, co8, ov8v;
    logic [31:0] a32, b32, s32;
    logic        c32, iv32, co32, ov32v;

`ifdef ADDER_N_BIT_OVF_EN
    logic ov4, ov1, ov8, ov32;
`endif

    int total;
    int bad;

    adder_n_bit #(.w(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(c4), .in_valid(iv4),
        .sum(s4), .cout(co4), .out_valid(ov4v)
`ifdef ADDER_N_BIT_OVF_EN
        , .ovf(ov4)
`endif
    );

    adder_n_bit #(.w(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1), .in_valid(iv1),
        .sum(s1), .cout(co1), .out_valid(ov1v)
`ifdef ADDER_N_BIT_OVF_EN
        , .ovf(ov1)
`endif
    );

    adder_n_bit #(.w(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8), .in_valid(iv8),
        .sum(s8), .cout(co8), .out_valid(ov8v)
`ifdef ADDER_N_BIT_OVF_EN
        , .ovf(ov8)
`endif
    );

    adder_n_bit #(.w(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(c32), .in_valid(iv32),
        .sum(s32), .cout(co32), .out_valid(ov32v)
`ifdef ADDER_N_BIT_OVF_EN
        , .ovf(ov32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer addition and sign rules.
    function automatic logic [65:0] ref_add(input int wd, input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [63:0] m;
        logic [64:0] full;
        logic [63:0] s;
        logic        co;
        logic        ov;
        m    = (wd == 64) ? '1 : ((64'd1 << wd) - 64'd1);
        full = {1'b0, a & m} + {1'b0, b & m} + 65'(cin);
        s    = full[63:0] & m;
        co   = full[wd];
        ov   = (a[wd-1] == b[wd-1]) && (s[wd-1] != a[wd-1]);
        return {ov, co, s};
    endfunction

    task automatic chk4(input string tag, input logic [65:0] e, input logic ev);
        chk({tag, "_sum4"}, 64'(s4), e[63:0]);
        chk({tag, "_cout4"}, 64'(co4), 64'(e[64]));
        chk({tag, "_vld4"}, 64'(ov4v), 64'(ev));
`ifdef ADDER_N_BIT_OVF_EN
        chk({tag, "_ovf4"}, 64'(ov4), 64'(e[65]));
`endif
    endtask

    task automatic chk1(input string tag, input logic [65:0] e, input logic ev);
        chk({tag, "_sum1"}, 64'(s1), e[63:0]);
        chk({tag, "_cout1"}, 64'(co1), 64'(e[64]));
        chk({tag, "_vld1"}, 64'(ov1v), 64'(ev));
`ifdef ADDER_N_BIT_OVF_EN
        chk({tag, "_ovf1"}, 64'(ov1), 64'(e[65]));
`endif
    endtask

    task automatic chk8(input string tag, input logic [65:0] e, input logic ev);
        chk({tag, "_sum8"}, 64'(s8), e[63:0]);
        chk({tag, "_cout8"}, 64'(co8), 64'(e[64]));
        chk({tag, "_vld8"}, 64'(ov8v), 64'(ev));
`ifdef ADDER_N_BIT_OVF_EN
        chk({tag, "_ovf8"}, 64'(ov8), 64'(e[65]));
`endif
    endtask

    task automatic chk32(input string tag, input logic [65:0] e, input logic ev);
        chk({tag, "_sum32"}, 64'(s32), e[63:0]);
        chk({tag, "_cout32"}, 64'(co32), 64'(e[64]));
        chk({tag, "_vld32"}, 64'(ov32v), 64'(ev));
`ifdef ADDER_N_BIT_OVF_EN
        chk({tag, "_ovf32"}, 64'(ov32), 64'(e[65]));
`endif
    endtask

    // Directed w=4 vectors: a, b, cin, expected {ovf, cout, sum}.
    logic [3:0] da [5];
    logic [3:0] db [5];
    logic       dc [5];
    logic [5:0] de [5];

    initial begin
        logic [65:0] e4, e1, e8, e32;
        logic        v4, v1, v8, v32;
        logic [2:0]  bits;

        total = 0;
        bad   = 0;

        da[0] = 4'h3; db[0] = 4'h5; dc[0] = 1'b0; de[0] = {1'b1, 1'b0, 4'h8};
        da[1] = 4'hF; db[1] = 4'h1; dc[1] = 1'b0; de[1] = {1'b0, 1'b1, 4'h0};
        da[2] = 4'h0; db[2] = 4'h0; dc[2] = 1'b1; de[2] = {1'b0, 1'b0, 4'h1};
        da[3] = 4'h8; db[3] = 4'h8; dc[3] = 1'b0; de[3] = {1'b1, 1'b1, 4'h0};
        da[4] = 4'h7; db[4] = 4'h1; dc[4] = 1'b0; de[4] = {1'b1, 1'b0, 4'h8};

        // Reset held for three edges with live, valid inputs.
        rst_n = 1'b0;
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; iv4 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; iv1 = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; iv8 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'h1; c32 = 1'b0; iv32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk4("rst", 66'd0, 1'b0);
            chk1("rst", 66'd0, 1'b0);
            chk8("rst", 66'd0, 1'b0);
            chk32("rst", 66'd0, 1'b0);
        end
        rst_n = 1'b1;

        // Directed w=4 vectors back to back.
        for (int i = 0; i < 5; i++) begin
            a4 = da[i]; b4 = db[i]; c4 = dc[i]; iv4 = 1'b1;
            @(negedge clk);
            chk4($sformatf("dir%0d", i), {de[i][5], de[i][4], 60'd0, de[i][3:0]}, 1'b1);
        end

        // w=1 exhaustive, one new input every cycle.
        for (int i = 0; i < 8; i++) begin
            bits = 3'(i);
            a1 = bits[0]; b1 = bits[1]; c1 = bits[2]; iv1 = 1'b1;
            e1 = ref_add(1, 64'(a1), 64'(b1), c1);
            @(negedge clk);
            chk1($sformatf("ex%0d", i), e1, 1'b1);
            chk($sformatf("ex%0d_total", i), 64'({co1, s1}), 64'(int'(bits[0]) + int'(bits[1]) + int'(bits[2])));
        end

        // Mid-stream reset on w=8: the wrap result lands, then reset clears it.
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        chk8("pre_rst", {1'b0, 1'b1, 64'd0}, 1'b1);
        rst_n = 1'b0;
        a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        chk8("mid_rst", 66'd0, 1'b0);
        rst_n = 1'b1;
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        chk8("post_rst", {1'b0, 1'b0, 64'h30}, 1'b1);

        // Randomized traffic on every width, valid toggling.
        for (int i = 0; i < 60; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); iv4 = 1'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); iv1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); iv8 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; c32 = 1'($urandom); iv32 = 1'($urandom);
            if (i % 10 == 0) begin
                a32 = 32'hFFFF_FFFF; b32 = 32'(i); c32 = 1'b1;
            end
            e4 = ref_add(4, 64'(a4), 64'(b4), c4);     v4 = iv4;
            e1 = ref_add(1, 64'(a1), 64'(b1), c1);     v1 = iv1;
            e8 = ref_add(8, 64'(a8), 64'(b8), c8);     v8 = iv8;
            e32 = ref_add(32, 64'(a32), 64'(b32), c32); v32 = iv32;
            @(negedge clk);
            chk4($sformatf("rnd%0d", i), e4, v4);
            chk1($sformatf("rnd%0d", i), e1, v1);
            chk8($sformatf("rnd%0d", i), e8, v8);
            chk32($sformatf("rnd%0d", i), e32, v32);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
